// File: rtl/csc_ycc2rgb_pipe.sv
// csc_ycc2rgb_pipe: three-stage YCbCr -> RGB colour-space converter.
// Stage 1 multiplies, stage 2 sums and adds bias, stage 3 rounds and clips.
// Data stages advance only with their de bit; vs/hs/de advance every cycle.
// Optional macro CSC_YCC2RGB_SHADOW_EN: when defined, coefficients, biases and
// bypass are captured into shadow registers on the rising edge of i_vs. When
// undefined, they feed stage 1 directly.
module csc_ycc2rgb_pipe #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned COEF_WIDTH = 12,
  parameter int unsigned BIAS_WIDTH = 8,
  parameter int unsigned RL         = 9
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  i_bypass,
  input  logic [COEF_WIDTH-1:0] i_coef00,
  input  logic [COEF_WIDTH-1:0] i_coef01,
  input  logic [COEF_WIDTH-1:0] i_coef02,
  input  logic [COEF_WIDTH-1:0] i_coef10,
  input  logic [COEF_WIDTH-1:0] i_coef11,
  input  logic [COEF_WIDTH-1:0] i_coef12,
  input  logic [COEF_WIDTH-1:0] i_coef20,
  input  logic [COEF_WIDTH-1:0] i_coef21,
  input  logic [COEF_WIDTH-1:0] i_coef22,
  input  logic [BIAS_WIDTH-1:0] i_bias0,
  input  logic [BIAS_WIDTH-1:0] i_bias1,
  input  logic [BIAS_WIDTH-1:0] i_bias2,
  input  logic                  i_vs,
  input  logic                  i_hs,
  input  logic                  i_de,
  input  logic [DATA_WIDTH-1:0] i_x0,
  input  logic [DATA_WIDTH-1:0] i_x1,
  input  logic [DATA_WIDTH-1:0] i_x2,
  output logic                  o_vs,
  output logic                  o_hs,
  output logic                  o_de,
  output logic [DATA_WIDTH-1:0] o_r,
  output logic [DATA_WIDTH-1:0] o_g,
  output logic [DATA_WIDTH-1:0] o_b
);

  localparam int unsigned XW = DATA_WIDTH + 1;
  localparam int unsigned PW = COEF_WIDTH + XW;
  localparam int unsigned AW = DATA_WIDTH + COEF_WIDTH + 3;
  localparam int unsigned RW = AW - RL + 1;

  // Signed coefficient x extended input; product fits exactly in PW bits.
  function automatic logic [PW-1:0] mul_term(input logic [COEF_WIDTH-1:0] c,
                                             input logic [DATA_WIDTH-1:0] x,
                                             input logic x_signed);
    logic signed [PW-1:0] ce;
    logic signed [PW-1:0] xe;
    logic signed [PW-1:0] p;
    ce = {{(PW-COEF_WIDTH){c[COEF_WIDTH-1]}}, c};
    xe = {{(PW-DATA_WIDTH){x_signed & x[DATA_WIDTH-1]}}, x};
    p  = ce * xe;
    return p;
  endfunction

  // Row sum of three products plus bias aligned to the fraction point.
  function automatic logic [AW-1:0] row_sum(input logic [PW-1:0] p0,
                                            input logic [PW-1:0] p1,
                                            input logic [PW-1:0] p2,
                                            input logic [BIAS_WIDTH-1:0] b);
    logic [AW-1:0] bext;
    bext = {{(AW-BIAS_WIDTH){b[BIAS_WIDTH-1]}}, b} << RL;
    return {{(AW-PW){p0[PW-1]}}, p0} + {{(AW-PW){p1[PW-1]}}, p1}
         + {{(AW-PW){p2[PW-1]}}, p2} + bext;
  endfunction

  // Round half up to integer, then clip to the unsigned output range.
  function automatic logic [DATA_WIDTH-1:0] round_clip(input logic [AW-1:0] s);
    logic [AW:0]   t;
    logic [RW-1:0] r;
    t = {s[AW-1], s} + ((AW+1)'(1) << (RL - 1));
    r = RW'($signed(t) >>> RL);
    if (r[RW-1])                      return '0;
    else if (|r[RW-2:DATA_WIDTH])     return '1;
    else                              return r[DATA_WIDTH-1:0];
  endfunction

  logic [COEF_WIDTH-1:0] coef_in  [9];
  logic [BIAS_WIDTH-1:0] bias_in  [3];
  logic [DATA_WIDTH-1:0] x_in     [3];
  logic [COEF_WIDTH-1:0] coef_use [9];
  logic [BIAS_WIDTH-1:0] bias_use [3];
  logic                  bypass_use;

  assign coef_in[0] = i_coef00;
  assign coef_in[1] = i_coef01;
  assign coef_in[2] = i_coef02;
  assign coef_in[3] = i_coef10;
  assign coef_in[4] = i_coef11;
  assign coef_in[5] = i_coef12;
  assign coef_in[6] = i_coef20;
  assign coef_in[7] = i_coef21;
  assign coef_in[8] = i_coef22;
  assign bias_in[0] = i_bias0;
  assign bias_in[1] = i_bias1;
  assign bias_in[2] = i_bias2;
  assign x_in[0]    = i_x0;
  assign x_in[1]    = i_x1;
  assign x_in[2]    = i_x2;

`ifdef CSC_YCC2RGB_SHADOW_EN
  logic                  vs_prev_q, vs_prev_d;
  logic                  vs_rise_c;
  logic [COEF_WIDTH-1:0] coef_sh_q [9];
  logic [COEF_WIDTH-1:0] coef_sh_d [9];
  logic [BIAS_WIDTH-1:0] bias_sh_q [3];
  logic [BIAS_WIDTH-1:0] bias_sh_d [3];
  logic                  bypass_sh_q, bypass_sh_d;

  // Capture a full coefficient set only on the rising edge of vs.
  always_comb begin
    vs_prev_d   = i_vs;
    vs_rise_c   = i_vs & ~vs_prev_q;
    coef_sh_d   = coef_sh_q;
    bias_sh_d   = bias_sh_q;
    bypass_sh_d = bypass_sh_q;
    if (vs_rise_c) begin
      coef_sh_d   = coef_in;
      bias_sh_d   = bias_in;
      bypass_sh_d = i_bypass;
    end
  end

  // Shadow registers; bypass defaults on so the block is transparent at reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vs_prev_q   <= 1'b0;
      bypass_sh_q <= 1'b1;
      for (int i = 0; i < 9; i++) coef_sh_q[i] <= '0;
      for (int i = 0; i < 3; i++) bias_sh_q[i] <= '0;
    end else begin
      vs_prev_q   <= vs_prev_d;
      bypass_sh_q <= bypass_sh_d;
      coef_sh_q   <= coef_sh_d;
      bias_sh_q   <= bias_sh_d;
    end
  end

  // Stage 1 always works from the shadow set.
  always_comb begin
    coef_use   = coef_sh_q;
    bias_use   = bias_sh_q;
    bypass_use = bypass_sh_q;
  end
`else
  // Stage 1 works from the live configuration inputs.
  always_comb begin
    coef_use   = coef_in;
    bias_use   = bias_in;
    bypass_use = i_bypass;
  end
`endif

  logic [PW-1:0]         prod_q [9],   prod_d [9];
  logic [DATA_WIDTH-1:0] raw_s1_q [3], raw_s1_d [3];
  logic [BIAS_WIDTH-1:0] bias_s1_q [3], bias_s1_d [3];
  logic                  byp_s1_q, byp_s1_d;
  logic [AW-1:0]         sum_q [3],    sum_d [3];
  logic [DATA_WIDTH-1:0] raw_s2_q [3], raw_s2_d [3];
  logic                  byp_s2_q, byp_s2_d;
  logic [DATA_WIDTH-1:0] rgb_q [3],    rgb_d [3];
  logic [2:0]            vs_q, vs_d, hs_q, hs_d, de_q, de_d;

  // Next-state for all pipeline stages; data stages hold when their de is low.
  always_comb begin
    prod_d    = prod_q;
    raw_s1_d  = raw_s1_q;
    bias_s1_d = bias_s1_q;
    byp_s1_d  = byp_s1_q;
    sum_d     = sum_q;
    raw_s2_d  = raw_s2_q;
    byp_s2_d  = byp_s2_q;
    rgb_d     = rgb_q;
    vs_d      = {vs_q[1:0], i_vs};
    hs_d      = {hs_q[1:0], i_hs};
    de_d      = {de_q[1:0], i_de};

    if (i_de) begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          prod_d[r*3+c] = mul_term(coef_use[r*3+c], x_in[c], c != 0);
        end
      end
      raw_s1_d  = x_in;
      bias_s1_d = bias_use;
      byp_s1_d  = bypass_use;
    end

    if (de_q[0]) begin
      for (int r = 0; r < 3; r++) begin
        sum_d[r] = row_sum(prod_q[r*3], prod_q[r*3+1], prod_q[r*3+2], bias_s1_q[r]);
      end
      raw_s2_d = raw_s1_q;
      byp_s2_d = byp_s1_q;
    end

    if (de_q[1]) begin
      for (int r = 0; r < 3; r++) begin
        rgb_d[r] = byp_s2_q ? raw_s2_q[r] : round_clip(sum_q[r]);
      end
    end
  end

  // Pipeline registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 9; i++) prod_q[i] <= '0;
      for (int i = 0; i < 3; i++) begin
        raw_s1_q[i]  <= '0;
        bias_s1_q[i] <= '0;
        sum_q[i]     <= '0;
        raw_s2_q[i]  <= '0;
        rgb_q[i]     <= '0;
      end
      byp_s1_q <= 1'b0;
      byp_s2_q <= 1'b0;
      vs_q     <= '0;
      hs_q     <= '0;
      de_q     <= '0;
    end else begin
      prod_q    <= prod_d;
      raw_s1_q  <= raw_s1_d;
      bias_s1_q <= bias_s1_d;
      byp_s1_q  <= byp_s1_d;
      sum_q     <= sum_d;
      raw_s2_q  <= raw_s2_d;
      byp_s2_q  <= byp_s2_d;
      rgb_q     <= rgb_d;
      vs_q      <= vs_d;
      hs_q      <= hs_d;
      de_q      <= de_d;
    end
  end

  assign o_r  = rgb_q[0];
  assign o_g  = rgb_q[1];
  assign o_b  = rgb_q[2];
  assign o_vs = vs_q[2];
  assign o_hs = hs_q[2];
  assign o_de = de_q[2];

endmodule

// File: tb/tb_csc_ycc2rgb_pipe.sv
// Directed bench for csc_ycc2rgb_pipe: vector table plus multi-cycle sequences.
// Expectations adapt to CSC_YCC2RGB_SHADOW_EN when that macro is defined.
module tb_csc_ycc2rgb_pipe;

  logic        clk = 1'b0;
  logic        rstn;
  logic        i_bypass;
  logic [11:0] c [9];
  logic [7:0]  b [3];
  logic        i_vs, i_hs, i_de;
  logic [7:0]  i_x0, i_x1, i_x2;
  logic        o_vs, o_hs, o_de;
  logic [7:0]  o_r, o_g, o_b;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  csc_ycc2rgb_pipe dut (
    .clk(clk), .rstn(rstn), .i_bypass(i_bypass),
    .i_coef00(c[0]), .i_coef01(c[1]), .i_coef02(c[2]),
    .i_coef10(c[3]), .i_coef11(c[4]), .i_coef12(c[5]),
    .i_coef20(c[6]), .i_coef21(c[7]), .i_coef22(c[8]),
    .i_bias0(b[0]), .i_bias1(b[1]), .i_bias2(b[2]),
    .i_vs(i_vs), .i_hs(i_hs), .i_de(i_de),
    .i_x0(i_x0), .i_x1(i_x1), .i_x2(i_x2),
    .o_vs(o_vs), .o_hs(o_hs), .o_de(o_de),
    .o_r(o_r), .o_g(o_g), .o_b(o_b)
  );

  typedef struct {
    string            name;
    logic [8:0][11:0] cf;
    logic [2:0][7:0]  bi;
    logic             byp;
    logic [2:0][7:0]  x;
    logic [2:0][7:0]  ex;
  } vec_t;

  vec_t vq[$];

  function automatic logic [8:0][11:0] mk(input int a00, input int a01, input int a02,
                                          input int a10, input int a11, input int a12,
                                          input int a20, input int a21, input int a22);
    logic [8:0][11:0] m;
    m[0] = 12'(a00); m[1] = 12'(a01); m[2] = 12'(a02);
    m[3] = 12'(a10); m[4] = 12'(a11); m[5] = 12'(a12);
    m[6] = 12'(a20); m[7] = 12'(a21); m[8] = 12'(a22);
    return m;
  endfunction

  function automatic logic [2:0][7:0] tri8(input int v0, input int v1, input int v2);
    logic [2:0][7:0] t;
    t[0] = 8'(v0); t[1] = 8'(v1); t[2] = 8'(v2);
    return t;
  endfunction

  task automatic add_vec(input string name, input logic [8:0][11:0] cf,
                         input logic [2:0][7:0] bi, input logic byp,
                         input logic [2:0][7:0] x, input logic [2:0][7:0] ex);
    vec_t v;
    v.name = name; v.cf = cf; v.bi = bi; v.byp = byp; v.x = x; v.ex = ex;
    vq.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic program_cfg(input logic [8:0][11:0] cf, input logic [2:0][7:0] bi,
                             input logic byp);
    for (int i = 0; i < 9; i++) c[i] = cf[i];
    for (int i = 0; i < 3; i++) b[i] = bi[i];
    i_bypass = byp;
  endtask

  task automatic vs_pulse();
    i_vs = 1'b1;
    tick();
    i_vs = 1'b0;
    tick();
  endtask

  task automatic set_px(input logic [2:0][7:0] x);
    i_x0 = x[0]; i_x1 = x[1]; i_x2 = x[2];
  endtask

  logic [8:0][11:0] id_c, fr_c, rd_c, zero_c;
  logic [2:0][7:0]  zb;
  logic [12:0]      vs_pat, hs_pat;

  initial begin
    id_c   = mk(512, 0, 0, 0, 512, 0, 0, 0, 512);
    fr_c   = mk(512, 0, 718, 512, -176, -366, 512, 907, 0);
    rd_c   = mk(256, 0, 0, 0, 0, 0, 0, 0, 0);
    zero_c = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    zb     = tri8(0, 0, 0);

    add_vec("ident_negclip", id_c, zb, 1'b0, tri8(100, 20, -30),   tri8(100, 20, 0));
    add_vec("ident_cbmin",   id_c, zb, 1'b0, tri8(0, -128, 127),   tri8(0, 0, 127));
    add_vec("fr_grey",       fr_c, zb, 1'b0, tri8(128, 0, 0),      tri8(128, 128, 128));
    add_vec("fr_rclip",      fr_c, zb, 1'b0, tri8(255, 0, 127),    tri8(255, 164, 255));
    add_vec("fr_negcb",      fr_c, zb, 1'b0, tri8(100, -100, 0),   tri8(100, 134, 0));
    add_vec("fr_halfup",     fr_c, zb, 1'b0, tri8(0, -128, -128),  tri8(0, 136, 0));
    add_vec("round_1p5",     rd_c, zb, 1'b0, tri8(3, 0, 0),        tri8(2, 0, 0));
    add_vec("round_0p5",     rd_c, zb, 1'b0, tri8(1, 0, 0),        tri8(1, 0, 0));
    add_vec("round_127p5",   rd_c, zb, 1'b0, tri8(255, 0, 0),      tri8(128, 0, 0));
    add_vec("bias",          id_c, tri8(-5, 10, 127), 1'b0, tri8(3, 10, 127), tri8(0, 20, 254));
    add_vec("bypass_fr",     fr_c, zb, 1'b1, tri8(200, 'h11, 'h22), tri8(200, 'h11, 'h22));

    rstn = 1'b0;
    program_cfg(zero_c, zb, 1'b0);
    i_vs = 1'b0; i_hs = 1'b0; i_de = 1'b0;
    set_px(zb);
    #12;
    check("reset_outputs", {5'd0, o_vs, o_hs, o_de, o_r, o_g, o_b}, 32'd0);
    tick();
    rstn = 1'b1;
    tick();

    // Bypass straight after reset: shadow build relies on the reset default.
`ifdef CSC_YCC2RGB_SHADOW_EN
    i_bypass = 1'b0;
`else
    i_bypass = 1'b1;
`endif
    set_px(tri8(7, 'hF0, 'h80));
    i_de = 1'b1;
    tick();
    i_de = 1'b0;
    tick(); tick();
    check("post_reset_bypass", {8'd0, o_r, o_g, o_b}, {8'd0, 8'd7, 8'hF0, 8'h80});
    i_bypass = 1'b0;
    tick();

    // Table-driven single-pixel vectors.
    foreach (vq[n]) begin
      program_cfg(vq[n].cf, vq[n].bi, vq[n].byp);
      vs_pulse();
      set_px(vq[n].x);
      i_de = 1'b1;
      tick();
      i_de = 1'b0;
      tick(); tick();
      check({vq[n].name, "_de"}, {31'd0, o_de}, 32'd1);
      check(vq[n].name, {8'd0, o_r, o_g, o_b}, {8'd0, vq[n].ex[0], vq[n].ex[1], vq[n].ex[2]});
      tick();
    end

    // Latency: o_de rises exactly three edges after the input pixel.
    program_cfg(id_c, zb, 1'b0);
    vs_pulse();
    set_px(tri8(100, 20, -30));
    i_de = 1'b1;
    tick();
    i_de = 1'b0;
    tick();
    check("lat_de_c2", {31'd0, o_de}, 32'd0);
    tick();
    check("lat_de_c3", {31'd0, o_de}, 32'd1);
    tick();
    check("lat_de_c4", {31'd0, o_de}, 32'd0);
    check("lat_hold", {8'd0, o_r, o_g, o_b}, {8'd0, 8'd100, 8'd20, 8'd0});

    // Coefficient change mid-frame while streaming Y=200.
    program_cfg(id_c, zb, 1'b0);
    vs_pulse();
    set_px(tri8(200, 0, 0));
    i_de = 1'b1;
    repeat (5) tick();
    check("shadow_before", {24'd0, o_r}, 32'd200);
    c[0] = 12'd256;
`ifdef CSC_YCC2RGB_SHADOW_EN
    repeat (5) tick();
    check("shadow_held", {24'd0, o_r}, 32'd200);
    i_vs = 1'b1;
    tick();
    i_vs = 1'b0;
    tick(); tick();
    check("shadow_vs_pixel_old", {24'd0, o_r}, 32'd200);
    tick();
    check("shadow_next_pixel_new", {24'd0, o_r}, 32'd100);
`else
    tick(); tick(); tick();
    check("live_coef_new", {24'd0, o_r}, 32'd100);
`endif
    i_de = 1'b0;
    repeat (4) tick();

    // Blanking: last pixel (50,0,0), then de low while vs/hs toggle.
    program_cfg(id_c, zb, 1'b0);
    vs_pulse();
    repeat (3) tick();
    vs_pat = 13'b0_1100_0111_0010;
    hs_pat = 13'b1_0101_0011_0110;
    set_px(tri8(50, 0, 0));
    i_de = 1'b1;
    i_vs = vs_pat[0];
    i_hs = hs_pat[0];
    tick();
    for (int k = 1; k <= 12; k++) begin
      if (k >= 3) begin
        check($sformatf("blank_r_%0d", k), {24'd0, o_r}, 32'd50);
        check($sformatf("blank_sync_%0d", k), {29'd0, o_vs, o_hs, o_de},
              {29'd0, vs_pat[k-3], hs_pat[k-3], (k == 3) ? 1'b1 : 1'b0});
      end
      i_de = 1'b0;
      i_vs = vs_pat[k];
      i_hs = hs_pat[k];
      tick();
    end
    i_vs = 1'b0;
    i_hs = 1'b0;

    // Asynchronous reset in the middle of a line.
    program_cfg(id_c, zb, 1'b0);
    vs_pulse();
    set_px(tri8(60, 0, 0));
    i_de = 1'b1;
    i_hs = 1'b1;
    repeat (4) tick();
    check("pre_reset_r", {24'd0, o_r}, 32'd60);
    #2;
    rstn = 1'b0;
    #1;
    check("async_reset", {5'd0, o_vs, o_hs, o_de, o_r, o_g, o_b}, 32'd0);
    i_de = 1'b0;
    i_hs = 1'b0;
    tick();
    rstn = 1'b1;
    tick();

    // After reset the shadow build is transparent again until the next vs rise.
    set_px(tri8(9, 'h33, 'hF0));
    i_de = 1'b1;
    tick();
    i_de = 1'b0;
    tick(); tick();
`ifdef CSC_YCC2RGB_SHADOW_EN
    check("reset_recover", {8'd0, o_r, o_g, o_b}, {8'd0, 8'd9, 8'h33, 8'hF0});
`else
    check("reset_recover", {8'd0, o_r, o_g, o_b}, {8'd0, 8'd9, 8'h33, 8'd0});
`endif
    tick();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
